hyperbus_tf_arbiter: RTL and testbench
======================================

HYPERBUS_TF_ARBITER -- requirements
Module: hyperbus_tf_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters sharing one HyperBus transaction channel (1..16).
REQ-002 SHALL have parameter TfWidth, default 64, width of the opaque transaction payload (transfer descriptor plus chip select).
REQ-003 SHALL have parameter TimeoutCycles, default 4096, maximum number of completion-wait cycles before a forced release (>=2).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk_i  in  1  system clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 req_tf_i  in  NumReq x TfWidth  per-requester transaction payload.
REQ-008 req_write_i  in  NumReq  per-requester direction: 1 = write, 0 = read.
REQ-009 req_valid_i  in  NumReq  per-requester request valid.
REQ-010 req_ready_o  out  NumReq  per-requester accept; one-hot or zero.
REQ-011 tf_o  out  TfWidth  registered payload to the transaction CDC.
REQ-012 tf_valid_o / tf_ready_i  out/in  1  downstream transaction handshake.
REQ-013 rx_valid_i, rx_ready_i, rx_last_i  in  1 each  monitored read-data handshake.
REQ-014 b_valid_i, b_ready_i  in  1 each  monitored write-response handshake.
REQ-015 owner_o  out  max(1,$clog2(NumReq))  index of the current owner; used to steer RX/B.
REQ-016 busy_o  out  1  high in every state except IDLE.
REQ-017 timeout_o  out  1  one-cycle pulse on forced release.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, WAIT_RD and WAIT_WR.
REQ-019 IDLE arbitration:
- Winner is the first index with req_valid_i set, searching from rr_ptr upward with wrap-around past NumReq-1.
- req_ready_o[winner] SHALL be driven combinationally, in the same cycle.
- No req_ready_o bit SHALL be driven outside IDLE.
REQ-020 On acceptance, SHALL register the payload into tf_o, the direction into a write flag, and the winner index into owner_o.
- SHALL set rr_ptr to (winner+1) mod NumReq.
- SHALL enter ISSUE.
REQ-021 ISSUE:
- tf_valid_o = 1, asserted the cycle after acceptance.
- tf_o and tf_valid_o SHALL stay stable until tf_ready_i.
- On tf_ready_i, SHALL go to WAIT_WR if the write flag is set, else WAIT_RD.
REQ-022 tf_valid_o SHALL be 0 in every state except ISSUE.
REQ-023 WAIT_RD SHALL return to IDLE in the cycle after rx_valid_i & rx_ready_i & rx_last_i.
- Non-last beats SHALL be ignored.
REQ-024 WAIT_WR SHALL return to IDLE in the cycle after b_valid_i & b_ready_i.
REQ-025 RX/B handshakes seen in IDLE or ISSUE SHALL be ignored, with no state change.
REQ-026 Wait counter:
- SHALL clear on entry to WAIT_RD or WAIT_WR and increment each cycle in those states.
- On reaching TimeoutCycles-1 with no completion: go to IDLE and pulse timeout_o for one cycle.
- A completion in that same cycle takes priority: no timeout pulse.
REQ-027 owner_o SHALL hold its value from acceptance until the next acceptance, including through IDLE.
REQ-028 A requester deasserting req_valid_i while not granted SHALL NOT affect state.
REQ-029 With NumReq=1, owner_o SHALL be constant 0 and the arbiter SHALL degenerate to single-outstanding sequencing.
REQ-030 Minimum turnaround SHALL be 1 IDLE cycle between a completion and the next acceptance.

Reset
REQ-031 While rst_i is high, independent of clk_i: state = IDLE, rr_ptr = 0, owner_o = 0, tf_o = 0, write flag = 0, wait counter = 0.
REQ-032 While rst_i is high: tf_valid_o = 0, req_ready_o = 0, busy_o = 0, timeout_o = 0.
REQ-033 Assertion of rst_i mid-transaction SHALL abandon the transaction with no completion or timeout pulse.

Verification
REQ-034 Single read: req 0 valid, write=0, payload 0xA5 -> req_ready_o=01 in cycle 0; tf_valid_o with tf_o=0xA5 from cycle 1; after tf_ready_i, busy_o stays 1 until the rx_last handshake, then 0.
REQ-035 Fairness: both requesters held valid, NumReq=2, back-to-back completions -> grant order 0,1,0,1; owner_o tracks each grant.
REQ-036 Write completion: write accepted, B handshake 5 cycles after tf_ready_i -> IDLE in the following cycle; an rx_last beat injected in WAIT_WR is ignored.
REQ-037 Timeout: TimeoutCycles=8, no completion -> timeout_o pulses exactly once, 8 cycles after entry to WAIT_RD; next grant goes to rr_ptr order.
REQ-038 Backpressure: tf_ready_i low for 10 cycles -> tf_o stable and tf_valid_o high throughout; req_valid_i from other requesters not acknowledged.
REQ-039 Reset during WAIT_RD -> all outputs at reset values immediately; after release, requester 0 granted first.

Source files
------------

// File: rtl/hyperbus_tf_arbiter.sv
// Round-robin arbiter that grants one requester at a time onto a shared HyperBus
// transaction channel and holds ownership until the read/write completion or a timeout.
module hyperbus_tf_arbiter #(
  parameter  int NumReq        = 2,
  parameter  int TfWidth       = 64,
  parameter  int TimeoutCycles = 4096,
  localparam int OwnerW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0][TfWidth-1:0]  req_tf_i,
  input  logic [NumReq-1:0]               req_write_i,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  output logic [TfWidth-1:0]              tf_o,
  output logic                            tf_valid_o,
  input  logic                            tf_ready_i,
  input  logic                            rx_valid_i,
  input  logic                            rx_ready_i,
  input  logic                            rx_last_i,
  input  logic                            b_valid_i,
  input  logic                            b_ready_i,
  output logic [OwnerW-1:0]               owner_o,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam int CntW = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } state_t;

  state_t            state;
  logic [OwnerW-1:0] rr_ptr;
  logic [OwnerW-1:0] winner;
  logic              grant_found;
  logic              is_write;
  logic [CntW-1:0]   wait_cnt;
  logic              rd_done;
  logic              wr_done;
  logic              wait_expired;

  assign rd_done      = rx_valid_i & rx_ready_i & rx_last_i;
  assign wr_done      = b_valid_i & b_ready_i;
  assign wait_expired = (wait_cnt == CntW'(TimeoutCycles - 1));

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority next time.
  always_comb begin : arb
    int idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    winner      = '0;
    idx         = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(rr_ptr) + i) % NumReq;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        winner      = OwnerW'(idx);
      end
    end
  end

  // Gated by rst_i so a request held during reset is never acknowledged.
  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && !rst_i && grant_found) req_ready_o[winner] = 1'b1;
  end

  assign tf_valid_o = (state == ISSUE);
  assign busy_o     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner_o   <= '0;
      tf_o      <= '0;
      is_write  <= 1'b0;
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            tf_o     <= req_tf_i[winner];
            is_write <= req_write_i[winner];
            owner_o  <= winner;
            rr_ptr   <= (winner == OwnerW'(NumReq - 1)) ? '0 : winner + 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (tf_ready_i) begin
            wait_cnt <= '0;
            state    <= is_write ? WAIT_WR : WAIT_RD;
          end
        end
        WAIT_RD, WAIT_WR: begin
          // Completion wins over an expiry landing in the same cycle.
          if ((state == WAIT_RD) ? rd_done : wr_done) begin
            state <= IDLE;
          end else if (wait_expired) begin
            state     <= IDLE;
            timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_tf_arbiter.sv
// Directed bench for hyperbus_tf_arbiter: reset, read/write sequencing, fairness,
// backpressure, timeout and mid-transaction reset, with hand-computed expectations.
module tb_hyperbus_tf_arbiter;

  localparam int NumReq        = 2;
  localparam int TfWidth       = 16;
  localparam int TimeoutCycles = 8;

  logic                           clk_i = 1'b0;
  logic                           rst_i;
  logic [NumReq-1:0][TfWidth-1:0] req_tf_i;
  logic [NumReq-1:0]              req_write_i;
  logic [NumReq-1:0]              req_valid_i;
  logic [NumReq-1:0]              req_ready_o;
  logic [TfWidth-1:0]             tf_o;
  logic                           tf_valid_o;
  logic                           tf_ready_i;
  logic                           rx_valid_i, rx_ready_i, rx_last_i;
  logic                           b_valid_i, b_ready_i;
  logic                           owner_o;
  logic                           busy_o;
  logic                           timeout_o;

  int errors = 0;
  int checks = 0;

  hyperbus_tf_arbiter #(
    .NumReq(NumReq), .TfWidth(TfWidth), .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_tf_i(req_tf_i), .req_write_i(req_write_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .tf_o(tf_o), .tf_valid_o(tf_valid_o), .tf_ready_i(tf_ready_i),
    .rx_valid_i(rx_valid_i), .rx_ready_i(rx_ready_i), .rx_last_i(rx_last_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk_i);
  endtask

  function automatic logic [15:0] payload(input int who);
    return (who == 1) ? 16'h1234 : 16'h00A5;
  endfunction

  // Caller has req_valid_i set at a falling edge with the DUT in IDLE.
  task automatic run_txn(input string tag, input int who, input logic wr);
    #1 check({tag, " grant"}, 32'(req_ready_o), 32'(1 << who));
    step(); #1;
    check({tag, " owner"}, 32'(owner_o), 32'(who));
    check({tag, " tf"}, 32'(tf_o), 32'(payload(who)));
    check({tag, " tf_valid"}, 32'(tf_valid_o), 32'd1);
    tf_ready_i = 1'b1;
    step();
    tf_ready_i = 1'b0;
    if (wr) begin b_valid_i = 1'b1; b_ready_i = 1'b1; end
    else    begin rx_valid_i = 1'b1; rx_ready_i = 1'b1; rx_last_i = 1'b1; end
    #1 check({tag, " busy in wait"}, 32'(busy_o), 32'd1);
    step();
    {rx_valid_i, rx_ready_i, rx_last_i, b_valid_i, b_ready_i} = '0;
    #1 check({tag, " idle after done"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int pulses;
    int first_k;
    rst_i       = 1'b1;
    req_tf_i[0] = payload(0);
    req_tf_i[1] = payload(1);
    req_write_i = '0;
    req_valid_i = 2'b11;
    tf_ready_i  = 1'b0;
    {rx_valid_i, rx_ready_i, rx_last_i, b_valid_i, b_ready_i} = '0;

    // Reset state with requests pending
    step(); step(); #1;
    check("rst ready", 32'(req_ready_o), 32'd0);
    check("rst tf_valid", 32'(tf_valid_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst owner", 32'(owner_o), 32'd0);
    check("rst tf", 32'(tf_o), 32'd0);
    req_valid_i = '0;
    step();
    rst_i = 1'b0;

    // RX/B handshakes in IDLE are ignored
    step();
    {rx_valid_i, rx_ready_i, rx_last_i, b_valid_i, b_ready_i} = '1;
    step();
    {rx_valid_i, rx_ready_i, rx_last_i, b_valid_i, b_ready_i} = '0;
    #1 check("idle ignores rx/b", 32'(busy_o), 32'd0);

    // Single read with a non-last beat first
    step();
    req_valid_i = 2'b01;
    #1 check("rd grant", 32'(req_ready_o), 32'b01);
    check("rd busy before accept", 32'(busy_o), 32'd0);
    step();
    req_valid_i = '0;
    #1 check("rd tf_valid", 32'(tf_valid_o), 32'd1);
    check("rd tf", 32'(tf_o), 32'h00A5);
    check("rd ready after accept", 32'(req_ready_o), 32'd0);
    tf_ready_i = 1'b1;
    step();
    tf_ready_i = 1'b0;
    rx_valid_i = 1'b1; rx_ready_i = 1'b1; rx_last_i = 1'b0;
    #1 check("rd tf_valid in wait", 32'(tf_valid_o), 32'd0);
    step();
    rx_last_i = 1'b1;
    #1 check("rd busy after non-last", 32'(busy_o), 32'd1);
    step();
    {rx_valid_i, rx_ready_i, rx_last_i} = '0;
    #1 check("rd done busy", 32'(busy_o), 32'd0);
    check("rd no timeout", 32'(timeout_o), 32'd0);

    // Write from requester 1; rx_last in WAIT_WR ignored, B at 5 cycles after tf_ready
    req_valid_i = 2'b10;
    req_write_i = 2'b10;
    #1 check("wr grant", 32'(req_ready_o), 32'b10);
    step();
    req_valid_i = '0;
    #1 check("wr owner", 32'(owner_o), 32'd1);
    check("wr tf", 32'(tf_o), 32'h1234);
    tf_ready_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      tf_ready_i = 1'b0;
      {rx_valid_i, rx_ready_i, rx_last_i} = (k == 2) ? 3'b111 : 3'b000;
      {b_valid_i, b_ready_i} = (k == 5) ? 2'b11 : 2'b00;
      #1;
      if (k == 3) check("wr rx_last ignored", 32'(busy_o), 32'd1);
      if (k == 5) check("wr busy at b", 32'(busy_o), 32'd1);
      if (k == 6) check("wr idle after b", 32'(busy_o), 32'd0);
    end
    {b_valid_i, b_ready_i} = '0;
    req_write_i = '0;

    // Fairness: both valid, back-to-back reads, rr_ptr now 0
    req_valid_i = 2'b11;
    run_txn("fair0", 0, 1'b0);
    run_txn("fair1", 1, 1'b0);
    run_txn("fair2", 0, 1'b0);
    run_txn("fair3", 1, 1'b0);

    // Backpressure: requester 0 granted, tf_ready held low 10 cycles
    req_valid_i = 2'b01;
    #1 check("bp grant", 32'(req_ready_o), 32'b01);
    for (int k = 0; k < 10; k++) begin
      step();
      req_valid_i = 2'b10;
      req_tf_i[0] = 16'(16'hBEE0 + k);
      #1;
      check("bp tf_valid", 32'(tf_valid_o), 32'd1);
      check("bp tf stable", 32'(tf_o), 32'h00A5);
      check("bp other not acked", 32'(req_ready_o), 32'd0);
    end
    req_tf_i[0] = payload(0);
    tf_ready_i = 1'b1;
    step();
    tf_ready_i  = 1'b0;
    req_valid_i = '0;

    // Timeout: WAIT_RD entered at the last edge; sample index k counts from 0
    pulses  = 0;
    first_k = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (timeout_o === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (k == 7) check("to busy before expiry", 32'(busy_o), 32'd1);
      if (k == 8) check("to idle at expiry", 32'(busy_o), 32'd0);
      step();
    end
    check("to pulse count", 32'(pulses), 32'd1);
    check("to pulse index", 32'(first_k), 32'd8);

    // Next grant follows rr_ptr (=1), then reset during WAIT_RD
    req_valid_i = 2'b11;
    #1 check("post-to grant", 32'(req_ready_o), 32'b10);
    step();
    tf_ready_i = 1'b1;
    step();
    tf_ready_i = 1'b0;
    step();
    rst_i = 1'b1;
    #1;
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst ready", 32'(req_ready_o), 32'd0);
    check("midrst tf_valid", 32'(tf_valid_o), 32'd0);
    check("midrst owner", 32'(owner_o), 32'd0);
    check("midrst tf", 32'(tf_o), 32'd0);
    check("midrst timeout", 32'(timeout_o), 32'd0);
    step();
    rst_i = 1'b0;
    #1 check("post-rst grant", 32'(req_ready_o), 32'b01);
    step(); #1;
    check("post-rst owner", 32'(owner_o), 32'd0);
    check("post-rst no timeout", 32'(timeout_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
